// File: rtl/cnn_layer_accel_wht_seq_table_array_pkg.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_wht_seq_table_array_pkg
// Shared definitions for the weight-sequence table array:
//   - default entry width, table depth and tables-per-AWE
//   - sequencer FSM state encoding (ST_IDLE / ST_RUN / ST_DRAIN)
// Optional feature macro used by the importing files: WHT_SEQ_TBL_PARITY_EN
// ---------------------------------------------------------------------------
package cnn_layer_accel_wht_seq_table_array_pkg;

  localparam int WHT_SEQ_WIDTH             = 8;
  localparam int NUM_WHT_SEQ_VALUES        = 64;
  localparam int NUM_WHT_SEQ_TABLE_PER_AWE = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/cnn_layer_accel_wht_seq_table_array_bank.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_wht_seq_table_array_bank
// One weight-sequence table: 1 synchronous write port, 2 combinational read
// ports. Storage is never reset.
// Ports:
//   clk                      clock
//   wr_en/wr_addr/wr_data    write port (already qualified by the caller)
//   rd0_addr/rd0_data        read port 0
//   rd1_addr/rd1_data        read port 1
//   rd0_par_err/rd1_par_err  parity mismatch per read port
//                            (only present with WHT_SEQ_TBL_PARITY_EN)
// Macro WHT_SEQ_TBL_PARITY_EN: store an even-parity bit alongside each entry.
// ---------------------------------------------------------------------------
module cnn_layer_accel_wht_seq_table_array_bank
  import cnn_layer_accel_wht_seq_table_array_pkg::*;
#(
  parameter int SEQ_WIDTH = WHT_SEQ_WIDTH,
  parameter int DEPTH     = NUM_WHT_SEQ_VALUES,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [SEQ_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd0_addr,
  output logic [SEQ_WIDTH-1:0] rd0_data,
  input  logic [ADDR_W-1:0]    rd1_addr,
`ifdef WHT_SEQ_TBL_PARITY_EN
  output logic [SEQ_WIDTH-1:0] rd1_data,
  output logic                 rd0_par_err,
  output logic                 rd1_par_err
`else
  output logic [SEQ_WIDTH-1:0] rd1_data
`endif
);

`ifdef WHT_SEQ_TBL_PARITY_EN
  // MSB holds the parity bit so that the XOR over the full entry is 0
  logic [SEQ_WIDTH:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {^wr_data, wr_data};
    end
  end

  logic [SEQ_WIDTH:0] rd0_entry;
  logic [SEQ_WIDTH:0] rd1_entry;

  assign rd0_entry   = mem[rd0_addr];
  assign rd1_entry   = mem[rd1_addr];
  assign rd0_data    = rd0_entry[SEQ_WIDTH-1:0];
  assign rd1_data    = rd1_entry[SEQ_WIDTH-1:0];
  assign rd0_par_err = ^rd0_entry;
  assign rd1_par_err = ^rd1_entry;
`else
  logic [SEQ_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd0_data = mem[rd0_addr];
  assign rd1_data = mem[rd1_addr];
`endif

endmodule

// File: rtl/cnn_layer_accel_wht_seq_table_array.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_wht_seq_table_array
// Bank of NUM_TABLES runtime-loadable weight-sequence tables plus a read
// sequencer that streams len consecutive entry pairs over valid/ready.
// Ports:
//   clk, rst                       clock, async active-high reset
//   cfg_wr_en/sel/addr/data        table write side, cfg_wr_rdy high in IDLE
//   seq_start/seq_base/seq_len     start a sequence (len 0..DEPTH)
//   seq_abort                      synchronous cancel, beats start
//   seq_busy, seq_done             status; seq_done is a 1-cycle pulse
//   out_valid/out_ready/out_last   beat handshake
//   seq_dout0/seq_dout1            lane k = table[k][ptr] / table[k][ptr+1]
//   seq_par_err                    sticky parity error
// Macro WHT_SEQ_TBL_PARITY_EN: enables per-entry parity and seq_par_err;
// without it seq_par_err is tied 0.
// ---------------------------------------------------------------------------
module cnn_layer_accel_wht_seq_table_array
  import cnn_layer_accel_wht_seq_table_array_pkg::*;
#(
  parameter  int NUM_TABLES = NUM_WHT_SEQ_TABLE_PER_AWE,
  parameter  int SEQ_WIDTH  = WHT_SEQ_WIDTH,
  parameter  int DEPTH      = NUM_WHT_SEQ_VALUES,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int SEL_W      = $clog2(NUM_TABLES) + 1,
  localparam int CNT_W      = ADDR_W + 1,
  localparam int DOUT_W     = SEQ_WIDTH * NUM_TABLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr_en,
  input  logic [SEL_W-1:0]  cfg_wr_sel,
  input  logic [ADDR_W-1:0] cfg_wr_addr,
  input  logic [SEQ_WIDTH-1:0] cfg_wr_data,
  output logic              cfg_wr_rdy,
  input  logic              seq_start,
  input  logic [ADDR_W-1:0] seq_base,
  input  logic [CNT_W-1:0]  seq_len,
  input  logic              seq_abort,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [DOUT_W-1:0] seq_dout0,
  output logic [DOUT_W-1:0] seq_dout1,
  output logic              seq_par_err
);

  seq_state_t        state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [ADDR_W-1:0] rd0_addr;
  logic [ADDR_W-1:0] rd1_addr;
  logic [DOUT_W-1:0] rd0_all;
  logic [DOUT_W-1:0] rd1_all;
  logic              wr_ok;
  logic              issue;

  assign cfg_wr_rdy = (state_reg == ST_IDLE);
  assign seq_busy   = (state_reg != ST_IDLE);

  // Out-of-range table selects never reach any bank
  assign wr_ok = cfg_wr_en && cfg_wr_rdy && (int'(cfg_wr_sel) < NUM_TABLES);

  // Second read port naturally wraps DEPTH-1 -> 0 since DEPTH is a power of two
  assign rd0_addr = ptr_reg;
  assign rd1_addr = ptr_reg + ADDR_W'(1);

  // A new beat may be loaded when the output register is empty or draining
  assign issue = (state_reg == ST_RUN) && (!out_valid || out_ready);

`ifdef WHT_SEQ_TBL_PARITY_EN
  logic [NUM_TABLES-1:0] par_err0;
  logic [NUM_TABLES-1:0] par_err1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TABLES; gi++) begin : gen_bank
      cnn_layer_accel_wht_seq_table_array_bank #(
        .SEQ_WIDTH (SEQ_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
      ) u_bank (
        .clk         (clk),
        .wr_en       (wr_ok && (cfg_wr_sel == SEL_W'(gi))),
        .wr_addr     (cfg_wr_addr),
        .wr_data     (cfg_wr_data),
        .rd0_addr    (rd0_addr),
        .rd0_data    (rd0_all[gi*SEQ_WIDTH +: SEQ_WIDTH]),
        .rd1_addr    (rd1_addr),
`ifdef WHT_SEQ_TBL_PARITY_EN
        .rd1_data    (rd1_all[gi*SEQ_WIDTH +: SEQ_WIDTH]),
        .rd0_par_err (par_err0[gi]),
        .rd1_par_err (par_err1[gi])
`else
        .rd1_data    (rd1_all[gi*SEQ_WIDTH +: SEQ_WIDTH])
`endif
      );
    end
  endgenerate

`ifndef WHT_SEQ_TBL_PARITY_EN
  assign seq_par_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      seq_done    <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      seq_dout0   <= '0;
      seq_dout1   <= '0;
`ifdef WHT_SEQ_TBL_PARITY_EN
      seq_par_err <= 1'b0;
`endif
    end else begin
      seq_done <= 1'b0;
      if (seq_abort) begin
        // Cancel drops any pending beat and does not report completion
        state_reg <= ST_IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (seq_start) begin
`ifdef WHT_SEQ_TBL_PARITY_EN
              seq_par_err <= 1'b0;
`endif
              if (seq_len != '0) begin
                ptr_reg   <= seq_base;
                cnt_reg   <= seq_len;
                state_reg <= ST_RUN;
              end else begin
                seq_done <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (issue) begin
              seq_dout0 <= rd0_all;
              seq_dout1 <= rd1_all;
              out_valid <= 1'b1;
              out_last  <= (cnt_reg == CNT_W'(1));
              ptr_reg   <= ptr_reg + ADDR_W'(1);
              cnt_reg   <= cnt_reg - CNT_W'(1);
              if (cnt_reg == CNT_W'(1)) begin
                state_reg <= ST_DRAIN;
              end
`ifdef WHT_SEQ_TBL_PARITY_EN
              if ((|par_err0) || (|par_err1)) begin
                seq_par_err <= 1'b1;
              end
`endif
            end
          end
          ST_DRAIN: begin
            if (out_valid && out_ready) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              seq_done  <= 1'b1;
              state_reg <= ST_IDLE;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
